onchip_memory_arbiter: RTL and testbench

Two-master Avalon-MM arbiter in front of the single-port 16K x 32 on-chip memory. It lets the Nios II data master (m0) and a second requester (m1, e.g. the JTAG/DMA loader) share the one memory port. Sharing is cycle-by-cycle round-robin: at most one transfer is accepted per cycle, and read data is routed back through a one-deep pipeline that matches the RAM's fixed one-cycle read latency. It sits between the system interconnect and the memory instance.

---
 rtl/onchip_memory_arbiter_if.sv | 26 ++
 rtl/onchip_memory_arbiter.sv | 85 ++++++++
 tb/tb_onchip_memory_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM requester bus between one master and the memory arbiter.
// master modport is the requester side; slave modport is the arbiter side.
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// One transfer per cycle; read data returns one cycle after acceptance; losers see combinational waitrequest.
module onchip_memory_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_rd_acc;

    logic r_last_grant;
    logic r_rd_pend;
    logic r_rd_owner;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    // On a tie the master that was not served last wins; nothing is granted in reset.
    assign w_gnt0 = ~reset & w_req0 & (~w_req1 | r_last_grant);
    assign w_gnt1 = ~reset & w_req1 & (~w_req0 | ~r_last_grant);

    // Read+write together is treated as a write, so it never opens a read slot.
    assign w_rd_acc = (w_gnt0 & m0.read & ~m0.write) |
                      (w_gnt1 & m1.read & ~m1.write);

    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        mem_write      = 1'b0;
        if (w_gnt1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_write      = m1.write;
        end else if (w_gnt0) begin
            mem_write      = m0.write;
        end
    end

    assign mem_chipselect = w_gnt0 | w_gnt1;
    assign mem_clken      = 1'b1;

    assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
    assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_last_grant <= 1'b0;
            end else if (w_gnt1) begin
                r_last_grant <= 1'b1;
            end
            r_rd_pend <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_owner <= w_gnt1;
            end
        end
    end

    // A read in flight when reset rises is dropped rather than delivered.
    assign m0.readdatavalid = ~reset & r_rd_pend & ~r_rd_owner;
    assign m1.readdatavalid = ~reset & r_rd_pend &  r_rd_owner;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: RAM model, reference scoreboard, directed then random traffic.
module tb_onchip_memory_arbiter;
    logic        clk;
    logic        rst;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    onchip_memory_arbiter_if bus0 ();
    onchip_memory_arbiter_if bus1 ();

    onchip_memory_arbiter dut (
        .clk            (clk),
        .reset          (rst),
        .m0             (bus0),
        .m1             (bus1),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory instance stand-in: registered read, byte-lane writes.
    logic [31:0] ram [16384];
    logic        ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 16384; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
        mem_readdata <= ram[mem_address];
    end

    // Requests each master is currently presenting.
    bit          rd [2];
    bit          wr [2];
    logic [13:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    int          mode;
    int          budget [2];

    // Reference model state.
    logic [31:0] ref_mem [16384];
    int          m_last;
    bit          m_pend;
    int          m_owner;
    logic [31:0] m_pdata;

    int n_pass, n_total;
    int rdv_cnt [2];
    int both_hi, wait1, ncyc;
    int order [$];
    int gq [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic wrq(int m);
        return (m == 1) ? bus1.waitrequest : bus0.waitrequest;
    endfunction
    function automatic logic rdvq(int m);
        return (m == 1) ? bus1.readdatavalid : bus0.readdatavalid;
    endfunction
    function automatic logic [31:0] rdat(int m);
        return (m == 1) ? bus1.readdata : bus0.readdata;
    endfunction

    task automatic set_req(int m, bit r, bit w, logic [13:0] a, logic [3:0] b, logic [31:0] d);
        rd[m] = r; wr[m] = w; addr[m] = a; be[m] = b; wd[m] = d;
    endtask

    task automatic rand_req(int m);
        int op;
        op = $urandom_range(0, 9);
        set_req(m, (op < 4) || (op >= 8), (op >= 4) && (op <= 8),
                14'($urandom_range(0, 15)), 4'($urandom), $urandom);
    endtask

    task automatic next_req(int m);
        if (mode == 1) begin
            budget[m]--;
            if (budget[m] > 0) set_req(m, 1, 0, 14'($urandom), 4'hF, 32'h0);
            else set_req(m, 0, 0, 14'h0, 4'h0, 32'h0);
        end else begin
            set_req(m, 0, 0, 14'h0, 4'h0, 32'h0);
        end
    endtask

    task automatic drive();
        bus0.read = rd[0]; bus0.write = wr[0]; bus0.address = addr[0];
        bus0.byteenable = be[0]; bus0.writedata = wd[0];
        bus1.read = rd[1]; bus1.write = wr[1]; bus1.address = addr[1];
        bus1.byteenable = be[1]; bus1.writedata = wd[1];
    endtask

    // One clock: entered and left at a falling edge.
    task automatic cycle();
        bit rq [2];
        bit ev;
        int w;
        if (mode == 2)
            for (int m = 0; m < 2; m++)
                if (!rd[m] && !wr[m] && $urandom_range(0, 2) != 0) rand_req(m);
        drive();
        #1;
        for (int m = 0; m < 2; m++) rq[m] = rd[m] | wr[m];
        w = -1;
        if (rst !== 1'b1) begin
            if (rq[0] && rq[1]) w = 1 - m_last;
            else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("waitreq%0d", m), 32'(wrq(m)), 32'((rst === 1'b1) || (rq[m] && w != m)));
            ev = (rst !== 1'b1) && m_pend && (m_owner == m);
            chk($sformatf("rdvalid%0d", m), 32'(rdvq(m)), 32'(ev));
            if (ev) chk($sformatf("rdata%0d", m), rdat(m), m_pdata);
            if (rdvq(m) === 1'b1) begin
                rdv_cnt[m]++;
                order.push_back(m);
            end
        end
        if (bus0.readdatavalid === 1'b1 && bus1.readdatavalid === 1'b1) both_hi++;
        if (rq[1] && bus1.waitrequest === 1'b1) wait1++;
        if (rst !== 1'b1 && rq[0] && bus0.waitrequest === 1'b0) gq.push_back(0);
        else if (rst !== 1'b1 && rq[1] && bus1.waitrequest === 1'b0) gq.push_back(1);
        chk("mem_cs", 32'(mem_chipselect), 32'(w >= 0));
        chk("mem_write", 32'(mem_write), 32'((w >= 0) ? wr[w] : 1'b0));
        if (w >= 0) begin
            chk("mem_addr", 32'(mem_address), 32'(addr[w]));
            if (wr[w]) begin
                chk("mem_be", 32'(mem_byteenable), 32'(be[w]));
                chk("mem_wdata", mem_writedata, wd[w]);
            end
        end
        if (rst === 1'b1) begin
            m_last = 1;
            m_pend = 0;
        end else begin
            m_pend = 0;
            if (w >= 0) begin
                m_last = w;
                if (wr[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[addr[w]][8*b +: 8] = wd[w][8*b +: 8];
                end else begin
                    m_pend  = 1;
                    m_owner = w;
                    m_pdata = ref_mem[addr[w]];
                end
                next_req(w);
            end
        end
        ncyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(int max);
        int k;
        k = 0;
        while ((rd[0] || wr[0] || rd[1] || wr[1]) && k < max) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(rd[0] || wr[0] || rd[1] || wr[1]), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; both_hi = 0; wait1 = 0; ncyc = 0;
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        mode = 0; m_last = 1; m_pend = 0; m_owner = 0; m_pdata = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        for (int m = 0; m < 2; m++) set_req(m, 0, 0, 14'h0, 4'h0, 32'h0);
        drive();
        rst = 1'b1;
        ram_fill = 1'b1;
        @(negedge clk);
        ram_fill = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Tied reads after reset: m0 first, m1 stalls once.
        order.delete(); wait1 = 0;
        set_req(0, 1, 0, 14'h0001, 4'hF, 32'h0);
        set_req(1, 1, 0, 14'h0002, 4'hF, 32'h0);
        cycle();
        chk("tie_rd0", bus0.readdata, 32'hA500_0001);
        cycle();
        chk("tie_rd1", bus1.readdata, 32'hA500_0002);
        cycle();
        chk("tie_order_n", order.size(), 2);
        chk("tie_order0", order[0], 0);
        chk("tie_order1", order[1], 1);
        chk("tie_m1_waits", wait1, 1);

        // m0 write then read-back.
        set_req(0, 0, 1, 14'h0010, 4'hF, 32'hDEADBEEF);
        cycle();
        set_req(0, 1, 0, 14'h0010, 4'hF, 32'h0);
        cycle();
        chk("wr_rd_valid", 32'(bus0.readdatavalid), 32'h1);
        chk("wr_rd_data", bus0.readdata, 32'hDEADBEEF);
        chk("wr_rd_m1_quiet", 32'(bus1.readdatavalid), 32'h0);
        cycle();

        // Streaming contention, 10 reads per master; m0 was served last so m1 leads.
        mode = 1; budget[0] = 10; budget[1] = 10;
        gq.delete(); both_hi = 0; rdv_cnt[0] = 0; rdv_cnt[1] = 0; ncyc = 0;
        set_req(0, 1, 0, 14'($urandom), 4'hF, 32'h0);
        set_req(1, 1, 0, 14'($urandom), 4'hF, 32'h0);
        run_idle(50);
        cycle();
        mode = 0;
        chk("stream_cycles", ncyc, 21);
        chk("stream_grants", gq.size(), 20);
        for (int i = 0; i < 20; i++) chk($sformatf("stream_alt%0d", i), gq[i], (i + 1) % 2);
        chk("stream_rdv0", rdv_cnt[0], 10);
        chk("stream_rdv1", rdv_cnt[1], 10);
        chk("stream_both_hi", both_hi, 0);

        // Byte-lane write on the top word.
        set_req(1, 0, 1, 14'h3FFF, 4'hF, 32'h11223344);
        cycle();
        set_req(1, 0, 1, 14'h3FFF, 4'h1, 32'h000000AA);
        cycle();
        set_req(1, 1, 0, 14'h3FFF, 4'hF, 32'h0);
        cycle();
        chk("byte_lane", bus1.readdata, 32'h112233AA);
        cycle();

        // Reset right after an accepted read drops its response.
        set_req(0, 1, 0, 14'h0005, 4'hF, 32'h0);
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_drop_rdv", 32'(bus0.readdatavalid), 32'h0);
        chk("rst_wait0", 32'(bus0.waitrequest), 32'h1);
        chk("rst_wait1", 32'(bus1.waitrequest), 32'h1);
        cycle();
        cycle();
        rst = 1'b0;
        set_req(0, 1, 0, 14'h0007, 4'hF, 32'h0);
        set_req(1, 1, 0, 14'h0008, 4'hF, 32'h0);
        drive();
        #1;
        chk("post_rst_gnt0", 32'(bus0.waitrequest), 32'h0);
        chk("post_rst_wait1", 32'(bus1.waitrequest), 32'h1);
        run_idle(10);
        cycle();

        // Read and write together behaves as a write.
        set_req(1, 1, 1, 14'h0100, 4'hF, 32'h5A5A5A5A);
        cycle();
        chk("rw_no_rdv", 32'(bus1.readdatavalid), 32'h0);
        set_req(1, 1, 0, 14'h0100, 4'hF, 32'h0);
        cycle();
        chk("rw_readback", bus1.readdata, 32'h5A5A5A5A);
        cycle();

        // Random mixed traffic over a small address window.
        mode = 2;
        for (int i = 0; i < 300; i++) cycle();
        mode = 0;
        run_idle(10);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
